// File: rtl/axi2mem_tcdm_slave.sv
// axi2mem_tcdm_slave
//   Multi-port TCDM responder. It arbitrates NB_PORTS request/grant initiator
//   ports onto one single-ported 32-bit word SRAM using round-robin priority.
//   Read data and write acknowledges are returned one cycle after the grant.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   tcdm_req_i      per-port request, held high until granted
//   tcdm_add_i      per-port byte address (word index = add[2 +: log2(MEM_WORDS)])
//   tcdm_we_i       per-port write enable (1 = write, 0 = read)
//   tcdm_wdata_i    per-port write data
//   tcdm_be_i       per-port byte enables (bit n -> byte n)
//   tcdm_gnt_o      combinational one-hot grant (all zero while in reset)
//   tcdm_r_rdata_o  per-port response data (0 for write acknowledges)
//   tcdm_r_valid_o  per-port one-cycle response pulse
//   stall_i         blocks all grants while high
module axi2mem_tcdm_slave #(
  parameter int unsigned NB_PORTS   = 4,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NB_PORTS-1:0]                 tcdm_req_i,
  input  logic [NB_PORTS-1:0][ADDR_WIDTH-1:0] tcdm_add_i,
  input  logic [NB_PORTS-1:0]                 tcdm_we_i,
  input  logic [NB_PORTS-1:0][31:0]           tcdm_wdata_i,
  input  logic [NB_PORTS-1:0][3:0]            tcdm_be_i,
  output logic [NB_PORTS-1:0]                 tcdm_gnt_o,
  output logic [NB_PORTS-1:0][31:0]           tcdm_r_rdata_o,
  output logic [NB_PORTS-1:0]                 tcdm_r_valid_o,
  input  logic                                stall_i
);

  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam int unsigned PW = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] nxt_ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] cand;
  logic          hit;
  logic [IW-1:0] widx;
  logic [31:0]   mem [MEM_WORDS];

  // Address bits outside the word index are intentionally ignored, so the
  // memory aliases modulo MEM_WORDS*4 bytes.
  logic          addr_unused;
  assign addr_unused = ^tcdm_add_i;

  // Scan ports starting at the round-robin pointer; the first requester wins.
  always_comb begin
    hit        = 1'b0;
    sel        = '0;
    cand       = '0;
    tcdm_gnt_o = '0;
    if (rst_ni && !stall_i) begin
      for (int unsigned i = 0; i < NB_PORTS; i++) begin
        cand = PW'((32'(rr_ptr) + i) % NB_PORTS);
        if (!hit && tcdm_req_i[cand]) begin
          hit = 1'b1;
          sel = cand;
        end
      end
    end
    if (hit) tcdm_gnt_o[sel] = 1'b1;
  end

  assign nxt_ptr = (32'(sel) == NB_PORTS - 1) ? '0 : sel + 1'b1;
  assign widx    = tcdm_add_i[sel][2 +: IW];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr         <= '0;
      tcdm_r_valid_o <= '0;
      tcdm_r_rdata_o <= '0;
    end else begin
      tcdm_r_valid_o <= '0;
      if (hit) begin
        tcdm_r_valid_o[sel] <= 1'b1;
        tcdm_r_rdata_o[sel] <= tcdm_we_i[sel] ? 32'h0 : mem[widx];
        rr_ptr              <= nxt_ptr;
      end
    end
  end

  // Storage is not reset; contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (hit && tcdm_we_i[sel]) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (tcdm_be_i[sel][b]) mem[widx][8*b +: 8] <= tcdm_wdata_i[sel][8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi2mem_tcdm_slave.sv
// tb_axi2mem_tcdm_slave
//   Directed scenarios followed by constrained-random traffic, all checked
//   against a behavioural model: a word array, a round-robin pointer and the
//   expected per-port response registers.
module tb_axi2mem_tcdm_slave;

  localparam int NP = 4;
  localparam int MW = 64;
  localparam int AW = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   stall;
  logic [NP-1:0]          req;
  logic [NP-1:0]          we;
  logic [NP-1:0][AW-1:0]  add;
  logic [NP-1:0][31:0]    wdata;
  logic [NP-1:0][3:0]     be;
  logic [NP-1:0]          gnt;
  logic [NP-1:0][31:0]    rdata;
  logic [NP-1:0]          rvalid;

  axi2mem_tcdm_slave #(
    .NB_PORTS  (NP),
    .MEM_WORDS (MW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tcdm_req_i    (req),
    .tcdm_add_i    (add),
    .tcdm_we_i     (we),
    .tcdm_wdata_i  (wdata),
    .tcdm_be_i     (be),
    .tcdm_gnt_o    (gnt),
    .tcdm_r_rdata_o(rdata),
    .tcdm_r_valid_o(rvalid),
    .stall_i       (stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int                  ptr;
  logic [31:0]         m [MW];
  logic [NP-1:0]       exp_rv;
  logic [NP-1:0][31:0] exp_rd;
  int                  last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (!rst_n || stall) return -1;
    for (int i = 0; i < NP; i++) begin
      if (req[(ptr + i) % NP]) return (ptr + i) % NP;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr    = 0;
    exp_rv = '0;
    exp_rd = '0;
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
    req[p]   = r;
    we[p]    = w;
    add[p]   = a;
    wdata[p] = d;
    be[p]    = b;
  endtask

  // Called at posedge+1: checks the grant mid-cycle, advances the model at the
  // edge and checks the response outputs just after it.
  task automatic tick();
    int g;
    int w;
    logic [NP-1:0] eg;
    #3;
    g  = pick();
    eg = (g >= 0) ? NP'(1 << g) : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    @(posedge clk);
    exp_rv = '0;
    if (!rst_n) begin
      model_reset();
    end else if (g >= 0) begin
      w         = int'((add[g] >> 2) % MW);
      exp_rv[g] = 1'b1;
      if (we[g]) begin
        for (int b = 0; b < 4; b++) if (be[g][b]) m[w][8*b +: 8] = wdata[g][8*b +: 8];
        exp_rd[g] = '0;
      end else begin
        exp_rd[g] = m[w];
      end
      ptr = (g + 1) % NP;
    end
    last_g = g;
    #1;
    chk("r_valid", 32'(rvalid), 32'(exp_rv));
    for (int k = 0; k < NP; k++) chk($sformatf("r_rdata%0d", k), rdata[k], exp_rd[k]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    rst_n  = 1'b1;
    stall  = 1'b0;
    req    = '0;
    we     = '0;
    add    = '0;
    wdata  = '0;
    be     = '0;
    last_g = -1;
    model_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // write then read back on port 0
    set_port(0, 1, 1, 32'h40, 32'hDEADBEEF, 4'hF); tick();
    set_port(0, 1, 0, 32'h40, 32'h0, 4'h0);        tick();
    req = '0; tick();
    chk("rd_deadbeef", rdata[0], 32'hDEADBEEF);

    // partial byte-enable merge
    set_port(0, 1, 1, 32'h80, 32'h11223344, 4'hF); tick();
    set_port(0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_port(1, 1, 1, 32'h80, 32'hAABBCCDD, 4'b0101); tick();
    set_port(1, 1, 0, 32'h80, 32'h0, 4'h0); tick();
    req = '0; tick();
    chk("be_merge", rdata[1], 32'h11BB33DD);

    // all ports read continuously from reset
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 1, 0, (p % 2) ? 32'h80 : 32'h40, 32'h0, 4'h0);
    repeat (8) tick();
    req = '0; tick();

    // stall blocks grants, then port 2 before port 3
    stall = 1'b1;
    set_port(2, 1, 0, 32'h40, 32'h0, 4'h0);
    set_port(3, 1, 0, 32'h80, 32'h0, 4'h0);
    repeat (3) tick();
    stall = 1'b0; tick();
    chk("stall_first", 32'(last_g), 32'd2);
    req[2] = 1'b0; tick();
    req = '0; tick();

    // address aliasing modulo MEM_WORDS*4
    d = $urandom;
    set_port(0, 1, 1, 32'h40, d, 4'hF); tick();
    set_port(0, 1, 0, 32'h40 + MW * 4, 32'h0, 4'h0); tick();
    req = '0; tick();
    chk("alias", rdata[0], d);

    // reset right after a grant drops the pending response and the pointer
    set_port(2, 1, 0, 32'h40, 32'h0, 4'h0); tick();
    req = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_drop", 32'(rvalid), 32'd0);
    tick();
    rst_n = 1'b1;
    set_port(1, 1, 0, 32'h40, 32'h0, 4'h0);
    set_port(3, 1, 0, 32'h80, 32'h0, 4'h0);
    #2;
    chk("rst_gnt", 32'(gnt), 32'h2);
    tick();
    req = '0; tick();

    // fill the memory, then random traffic with held un-granted requests
    for (int w = 0; w < MW; w++) begin
      set_port(0, 1, 1, 32'(w * 4), $urandom, 4'hF);
      tick();
    end
    req = '0;
    last_g = -1;
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req[p] || last_g == p)
          set_port(p, $urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom, 4'($urandom));
      end
      stall = ($urandom_range(0, 7) == 0);
      tick();
    end
    stall = 1'b0;
    req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi2mem_tcdm_slave.md
Name: axi2mem_tcdm_slave

Overview:
- Multi-port TCDM responder: the memory end of the TCDM request/grant and response-valid protocol driven by the axi2mem TCDM initiator ports.
- Arbitrates NB_PORTS initiator ports onto one single-ported word SRAM with round-robin priority.
- Returns read data and write acknowledges one cycle after grant.
- Used as the memory model in axi2mem unit and system benches, and as a synthesizable scratch bank.

Parameters:
- NB_PORTS, 4, number of TCDM initiator ports.
- MEM_WORDS, 1024, number of 32-bit words (power of 2, at least 2).
- ADDR_WIDTH, 32, width of the byte address per port.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- tcdm_req_i  in  NB_PORTS  request per port; held high until granted.
- tcdm_add_i  in  NB_PORTS x ADDR_WIDTH  byte address.
- tcdm_we_i  in  NB_PORTS  1 = write, 0 = read.
- tcdm_wdata_i  in  NB_PORTS x 32  write data.
- tcdm_be_i  in  NB_PORTS x 4  byte enables (bit n maps to byte n).
- tcdm_gnt_o  out  NB_PORTS  grant, combinational from request, at most one bit high.
- tcdm_r_rdata_o  out  NB_PORTS x 32  response data.
- tcdm_r_valid_o  out  NB_PORTS  response valid, one-cycle pulse.
- stall_i  in  1  bench/contention throttle; 1 blocks all grants.

Behaviour:
- One clock (clk_i), asynchronous active-low reset (rst_ni).
- Reset values:
  - tcdm_r_valid_o = 0, tcdm_r_rdata_o = 0, RR pointer = 0.
  - tcdm_gnt_o forced to 0 while rst_ni = 0.
  - Memory contents are not reset.
- Word index = tcdm_add_i[2 +: log2(MEM_WORDS)].
  - Bits [1:0] are ignored.
  - Upper bits are ignored, so addresses alias modulo MEM_WORDS*4.
- Arbitration:
  - Each cycle with stall_i = 0, the first requesting port at or after the RR pointer (wrapping modulo NB_PORTS) is granted.
  - Only that port's gnt bit is high; the grant is decided in the same cycle as the request.
  - No request, or stall_i = 1: all gnt = 0 and the pointer is unchanged.
- Pointer update: after a grant to port k, the pointer becomes (k+1) mod NB_PORTS at the clock edge.
- Grant handshake:
  - The access happens at the rising edge where req & gnt = 1.
  - A port with req high and no grant must hold its address, we, wdata and be stable.
  - The block does not check this.
- Read access:
  - At the grant edge, the word is latched into that port's r_rdata register.
  - The next cycle, r_valid_o[k] = 1 for exactly one cycle.
- Write access:
  - Bytes with be = 1 are updated at the grant edge; other bytes keep their value.
  - be = 0000 writes nothing but is still acknowledged.
  - The next cycle, r_valid_o[k] = 1 and r_rdata_o[k] = 0.
- Latency: exactly 1 cycle from grant to r_valid for both reads and writes.
  - Back-to-back grants to one port give back-to-back r_valid pulses.
  - A port may issue its next request in the same cycle its r_valid is high.
- r_rdata_o[k] holds its last value until the port's next granted read or write.
- Ordering:
  - A read granted the cycle after a write to the same word returns the new data.
  - Same-cycle conflicts cannot occur because only one grant is given per cycle.
- Reset mid-operation: a pending response is dropped (r_valid = 0) and the pointer returns to 0; memory contents are kept.
- Maximum throughput is one access per cycle in total across all ports.

Test Plan:
- Port0 writes 0xDEADBEEF to 0x40 with be = F, then reads 0x40 -> gnt same cycle, r_valid[0] one cycle later each time, read data 0xDEADBEEF, write response data 0.
- Write 0x11223344 to 0x80, then port1 writes 0xAABBCCDD to 0x80 with be = 0101, then reads 0x80 -> 0x11BB33DD.
- All 4 ports request reads continuously from reset -> grants 0,1,2,3,0,1,... one per cycle; each r_valid lags its gnt by 1 cycle.
- stall_i = 1 for 3 cycles while ports 2 and 3 request -> no gnt and no r_valid; after release, port2 is granted first, then port3.
- Port0 write then port0 read at address 0x40 + MEM_WORDS*4 -> returns the data written to 0x40 (aliasing).
- rst_ni pulsed low the cycle after a grant -> r_valid stays 0; the next grant after reset goes to the lowest-index requester.
